debug_trace_fifo: RTL

Retirement-trace buffer at the far end of the debug pipeline chain. Consumes the per-instruction debug tick and instruction word that travel alongside the core pipeline. Captures one record per retired, non-bubble instruction into a circular FIFO. Presents the records to a debug host through a valid/ready read port.

---
 rtl/debug_trace_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/debug_trace_fifo.sv
// -----------------------------------------------------------------------------
// debug_trace_fifo
//
// Retirement-trace buffer. Captures one {tick, instruction} record per retired,
// non-bubble instruction into a circular FIFO and serves the records to a debug
// host through a show-ahead valid/ready read port.
//
// Ports:
//   i_clock       clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_enable      capture enable from the debug host
//   i_stopOnFull  1: freeze capture on overflow, 0: drop and count overflow
//   i_clear       synchronous clear of FIFO, dropped counter and freeze state
//   i_dbgRetire   retirement strobe
//   i_dbgTick     tick number of the retiring instruction
//   i_dbgInst     retiring instruction word (0 = bubble)
//   o_rdValid     head record available
//   i_rdReady     host accepts the head record
//   o_rdTick      head record tick (0 when empty)
//   o_rdInst      head record instruction (0 when empty)
//   o_count       number of stored records
//   o_empty       count == 0
//   o_full        count == DEPTH
//   o_dropped     saturating count of records lost while full
//   o_state       0 IDLE, 1 CAPTURE, 2 FROZEN
// -----------------------------------------------------------------------------
module debug_trace_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DROP_WIDTH = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_stopOnFull,
    input  logic                    i_clear,
    input  logic                    i_dbgRetire,
    input  logic [31:0]             i_dbgTick,
    input  logic [31:0]             i_dbgInst,
    output logic                    o_rdValid,
    input  logic                    i_rdReady,
    output logic [31:0]             o_rdTick,
    output logic [31:0]             o_rdInst,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [DROP_WIDTH-1:0]   o_dropped,
    output logic [1:0]              o_state
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFrozen  = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;
    logic [DROP_WIDTH-1:0] r_dropped;
    logic [31:0]           r_mem_tick [DEPTH];
    logic [31:0]           r_mem_inst [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_candidate;
    logic w_capture;
    logic w_pop;
    logic w_push;
    logic w_overflow;
    logic w_drop;
    logic w_freeze;

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == FullCount);
        w_candidate = i_dbgRetire && (i_dbgInst != 32'd0);
        w_capture   = (r_state == StCapture) && w_candidate;
        w_pop       = !w_empty && i_rdReady;
        // A pop in the same cycle frees the slot the candidate needs.
        w_push      = w_capture && (!w_full || w_pop);
        w_overflow  = w_capture && w_full && !w_pop;
        w_drop      = w_overflow && !i_stopOnFull;
        // The freezing candidate is neither stored nor counted as dropped.
        w_freeze    = w_overflow && i_stopOnFull;
    end

    // Next-state logic; clear overrides everything, including FROZEN.
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = i_enable ? StCapture : StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        w_state_next = StCapture;
                    end
                end
                StCapture: begin
                    if (w_freeze) begin
                        w_state_next = StFrozen;
                    end else if (!i_enable) begin
                        w_state_next = StIdle;
                    end
                end
                StFrozen: begin
                    w_state_next = StFrozen;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= StIdle;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else begin
            r_state <= w_state_next;
            if (i_clear) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_dropped <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PtrW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CntW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CntW'(1);
                end
                if (w_drop && (r_dropped != '1)) begin
                    r_dropped <= r_dropped + DROP_WIDTH'(1);
                end
            end
        end
    end

    // Storage has no reset; entries are only visible once counted.
    always_ff @(posedge i_clock) begin
        if (w_push && !i_clear) begin
            r_mem_tick[r_wr_ptr] <= i_dbgTick;
            r_mem_inst[r_wr_ptr] <= i_dbgInst;
        end
    end

    always_comb begin
        o_rdValid = !w_empty;
        // Gate with empty so the read port shows zeros after reset.
        o_rdTick  = w_empty ? 32'd0 : r_mem_tick[r_rd_ptr];
        o_rdInst  = w_empty ? 32'd0 : r_mem_inst[r_rd_ptr];
        o_count   = r_count;
        o_empty   = w_empty;
        o_full    = w_full;
        o_dropped = r_dropped;
        o_state   = r_state;
    end

endmodule
